dbram_stream_reader: RTL

//  - Read-side sequencer for the 2048x60 double-buffered BRAM: streams LEN words from BASE_ADDR
//    out of RAM port A onto a valid/ready stream.
//  - Fixed RAM read latency is absorbed by an in-flight valid pipe plus a small output FIFO.

---
 rtl/dbram_stream_reader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dbram_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dbram_stream_reader: streams LEN words from BASE_ADDR of the 2048x60     |
// | double-buffered BRAM (port A) onto a valid/ready stream, absorbing the   |
// | fixed RAM read latency with a credit-checked valid pipe and output FIFO. |
// | Optional m_last output: define DBRAM_READER_LAST_EN.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dbram_stream_reader #(
  parameter int AWIDTH     = 11,
  parameter int DWIDTH     = 60,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   len,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_wren,
  input  logic [DWIDTH-1:0] ram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data
`ifdef DBRAM_READER_LAST_EN
  ,
  output logic              m_last
`endif
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 2;
  localparam logic [c_CW-1:0]   c_DEPTH_W = c_CW'(FIFO_DEPTH);
  localparam logic [c_PW:0]     c_DEPTH_C = (c_PW+1)'(FIFO_DEPTH);
  localparam logic [c_PW:0]     c_CNT_ONE = (c_PW+1)'(1);
  localparam logic [AWIDTH:0]   c_LEN_ONE = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] c_ADR_ONE = AWIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [AWIDTH:0]       r_remaining;
  logic [RD_LATENCY-1:0] r_pipe_v;
  logic [DWIDTH-1:0]     r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]       r_wr_ptr;
  logic [c_PW-1:0]       r_rd_ptr;
  logic [c_PW:0]         r_count;

  logic [c_CW-1:0]       w_inflight;
  logic [c_PW:0]         w_count_next;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drained;

  assign ram_wren = 1'b0;
  assign m_data   = r_mem[r_rd_ptr];
  assign w_push   = r_pipe_v[RD_LATENCY-1];
  assign w_pop    = m_valid & m_ready;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + c_CW'(r_pipe_v[i]);
    end
  end

  // Credit: every issued-but-unpopped word already owns a FIFO slot.
  assign w_issue = (r_state == S_ISSUE) && ((c_CW'(r_count) + w_inflight) < c_DEPTH_W);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_CNT_ONE;
    end
  end

  // FIFO empties at this edge, so done lands the cycle after the last handshake.
  assign w_drained = (r_pipe_v == '0) &&
                     ((r_count == '0) || ((r_count == c_CNT_ONE) && w_pop));

`ifdef DBRAM_READER_LAST_EN
  logic [RD_LATENCY-1:0] r_pipe_l;
  logic                  r_mem_l [FIFO_DEPTH];
  logic                  w_issue_last;

  assign w_issue_last = w_issue && (r_remaining == c_LEN_ONE);
  assign m_last       = r_mem_l[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_l <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_l[i] <= 1'b0;
      end
    end else begin
      r_pipe_l[0] <= w_issue_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_l[i] <= r_pipe_l[i-1];
      end
      if (w_push) begin
        r_mem_l[r_wr_ptr] <= r_pipe_l[RD_LATENCY-1];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_pipe_v    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_addr    <= '0;
      m_valid     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            ram_addr    <= base_addr;
            r_remaining <= len;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              busy    <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            ram_addr    <= ram_addr + c_ADR_ONE;
            r_remaining <= r_remaining - c_LEN_ONE;
            if (r_remaining == c_LEN_ONE) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      r_pipe_v[0] <= w_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
      end

      assert (!(w_push && !w_pop && (r_count == c_DEPTH_C)));
      if (w_push) begin
        r_mem[r_wr_ptr] <= ram_rdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      m_valid <= (w_count_next != '0);
    end
  end

endmodule
`default_nettype wire
